// File: rtl/uart_rx_os.sv
// UART receiver driven by an oversampling tick.
// It synchronises the serial line, finds the start bit and samples each bit at mid-period.
// Each completed frame goes into a single-entry valid/ready holding register, along with its error flags.
// If the holding register is still full when a frame completes, that frame is dropped and overrun_err pulses.
module uart_rx_os #(
    parameter int DATA_BITS   = 8,
    parameter int OS_RATE     = 16,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 os_tick,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int              TW        = $clog2(OS_RATE);
    localparam logic [TW-1:0]   TICK_MID  = TW'(OS_RATE / 2 - 1);
    localparam logic [TW-1:0]   TICK_LAST = TW'(OS_RATE - 1);
    localparam logic [3:0]      BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic            STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [3:0]             bit_q, bit_d;
    logic                   stop_q, stop_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;      // running XOR of data and parity samples
    logic                   fe_q, fe_d;        // some stop sample was low
    logic                   hi_q, hi_d;        // some sample of the frame was high
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   brk_q, brk_d;
    logic                   ovr_q, ovr_d;
    logic                   busy_q, busy_d;
    logic                   rx_s;
    logic                   frame_done;
    logic                   perr_calc;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Next-state logic: the synchroniser, the frame FSM on each tick, and the holding register.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], uart_rx};
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        shift_d    = shift_q;
        par_d      = par_q;
        fe_d       = fe_q;
        hi_d       = hi_q;
        frame_done = 1'b0;

        if (os_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d = S_START;
                        tick_d  = '0;
                    end
                end
                S_START: begin
                    if (tick_q == TICK_MID) begin
                        if (rx_s) begin
                            state_d = S_IDLE;           // glitch / false start
                        end else begin
                            state_d = S_DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                            shift_d = '0;
                            par_d   = 1'b0;
                            fe_d    = 1'b0;
                            hi_d    = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                S_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        // LSB arrives first, so shift in from the top
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        par_d   = par_q ^ rx_s;
                        hi_d    = hi_q | rx_s;
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == BIT_LAST) begin
                            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                            stop_d  = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                S_PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        par_d   = par_q ^ rx_s;
                        hi_d    = hi_q | rx_s;
                        state_d = S_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                S_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        fe_d   = fe_q | ~rx_s;
                        hi_d   = hi_q | rx_s;
                        if (stop_q == STOP_LAST) begin
                            frame_done = 1'b1;
                            state_d    = S_IDLE;        // ready for a start bit right after mid-stop
                        end else begin
                            stop_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (PARITY == 1) begin
            perr_calc = ~par_d;
        end else if (PARITY == 2) begin
            perr_calc = par_d;
        end else begin
            perr_calc = 1'b0;
        end

        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        brk_d   = brk_q;
        valid_d = valid_q && !rx_ready;
        ovr_d   = 1'b0;
        if (frame_done) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_d;
                valid_d = 1'b1;
                perr_d  = perr_calc;
                ferr_d  = fe_d;
                brk_d   = ~hi_d;
            end else begin
                ovr_d = 1'b1;                   // register still full: drop this frame
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs, asynchronously cleared by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sync_q  <= '1;
            tick_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            fe_q    <= 1'b0;
            hi_q    <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            fe_q    <= fe_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign break_det   = brk_q;
    assign overrun_err = ovr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Testbench for uart_rx_os.
// Three receivers share the same serial line: 8N1, 8E1, and 7N2 with a 3-stage synchroniser.
// The line is built one os_tick level at a time. For each receiver, a frame-level model
// derives the frames it should see from that tick sequence.
module tb_uart_rx_os;

    localparam int OS = 16;

    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       bk;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       os_tick = 1'b0;
    logic       uart_rx = 1'b1;
    logic [2:0] rdy = 3'b111;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic [2:0] valid, pe, fe, bk, ovr, busy;
    logic [8:0] dat [3];

    int checks = 0;
    int errors = 0;
    int ovr_cnt [3] = '{0, 0, 0};
    int exp_ovr [3] = '{0, 0, 0};
    int cfg_db  [3] = '{8, 8, 7};
    int cfg_par [3] = '{0, 2, 0};
    int cfg_sb  [3] = '{1, 1, 2};

    bit     seg [$];
    frame_t exp0 [$];
    frame_t exp1 [$];
    frame_t exp2 [$];
    frame_t mon_e;
    bit     mon_have;

    always #5 clk = ~clk;

    uart_rx_os u0 (
        .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .uart_rx(uart_rx),
        .rx_data(d0), .rx_valid(valid[0]), .rx_ready(rdy[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .break_det(bk[0]),
        .overrun_err(ovr[0]), .busy(busy[0])
    );

    uart_rx_os #(.PARITY(2)) u1 (
        .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .uart_rx(uart_rx),
        .rx_data(d1), .rx_valid(valid[1]), .rx_ready(rdy[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .break_det(bk[1]),
        .overrun_err(ovr[1]), .busy(busy[1])
    );

    uart_rx_os #(.DATA_BITS(7), .STOP_BITS(2), .SYNC_STAGES(3)) u2 (
        .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .uart_rx(uart_rx),
        .rx_data(d2), .rx_valid(valid[2]), .rx_ready(rdy[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .break_det(bk[2]),
        .overrun_err(ovr[2]), .busy(busy[2])
    );

    assign dat[0] = {1'b0, d0};
    assign dat[1] = {1'b0, d1};
    assign dat[2] = {2'b00, d2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void push_exp(input int i, input frame_t f);
        case (i)
            0:       exp0.push_back(f);
            1:       exp1.push_back(f);
            default: exp2.push_back(f);
        endcase
    endfunction

    function automatic bit pop_exp(input int i, output frame_t f);
        f = '0;
        pop_exp = 1'b0;
        case (i)
            0:       if (exp0.size() > 0) begin f = exp0.pop_front(); pop_exp = 1'b1; end
            1:       if (exp1.size() > 0) begin f = exp1.pop_front(); pop_exp = 1'b1; end
            default: if (exp2.size() > 0) begin f = exp2.pop_front(); pop_exp = 1'b1; end
        endcase
    endfunction

    function automatic int exp_size(input int i);
        case (i)
            0:       return exp0.size();
            1:       return exp1.size();
            default: return exp2.size();
        endcase
    endfunction

    // Watch every accepted transfer and every overrun pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (ovr[i]) ovr_cnt[i]++;
                if (valid[i] && rdy[i]) begin
                    $display("u%0d rx data=%0h pe=%b fe=%b bk=%b", i, dat[i], pe[i], fe[i], bk[i]);
                    mon_have = pop_exp(i, mon_e);
                    if (!mon_have) begin
                        check($sformatf("u%0d_unexpected_valid", i), 32'd1, 32'd0);
                    end else begin
                        check($sformatf("u%0d_data", i), dat[i], mon_e.data);
                        check($sformatf("u%0d_parity_err", i), pe[i], mon_e.pe);
                        check($sformatf("u%0d_frame_err", i), fe[i], mon_e.fe);
                        check($sformatf("u%0d_break_det", i), bk[i], mon_e.bk);
                    end
                end
            end
        end
    end

    task automatic add_ticks(input bit level, input int n);
        repeat (n) seg.push_back(level);
    endtask

    task automatic add_bits(input bit level, input int n);
        add_ticks(level, n * OS);
    endtask

    // Append one frame laid out for configuration c.
    task automatic add_frame(input int c, input int data, input bit flip_par,
                             input bit [1:0] stop_low, input int gap_bits);
        int  db;
        bit  p;
        db = cfg_db[c];
        add_bits(1'b0, 1);
        for (int k = 0; k < db; k++) add_bits(bit'((data >> k) & 1), 1);
        if (cfg_par[c] != 0) begin
            p = 1'b0;
            for (int k = 0; k < db; k++) p ^= bit'((data >> k) & 1);
            if (cfg_par[c] == 1) p = ~p;
            if (flip_par) p = ~p;
            add_bits(p, 1);
        end
        for (int k = 0; k < cfg_sb[c]; k++) add_bits(~stop_low[k], 1);
        add_bits(1'b1, gap_bits);
    endtask

    // Frame-level reference: walks the tick sequence, finding the start edges
    // and the mid-bit sample points with plain index arithmetic.
    task automatic model(input int i);
        int     n, j, s, last, db, np, sb;
        bit     p, x, allzero;
        frame_t f;
        n  = seg.size();
        db = cfg_db[i];
        np = (cfg_par[i] != 0) ? 1 : 0;
        sb = cfg_sb[i];
        j  = 0;
        while (j < n) begin
            if (seg[j]) begin
                j++;
                continue;
            end
            s = j + OS / 2;
            if (s >= n) break;
            if (seg[s]) begin
                j = s + 1;
                continue;
            end
            last = s + OS * (db + np + sb);
            if (last >= n) break;
            f = '0;
            x = 1'b0;
            for (int k = 0; k < db; k++) begin
                f.data[k] = seg[s + OS * (k + 1)];
                x ^= seg[s + OS * (k + 1)];
            end
            allzero = (f.data == 9'd0);
            if (np != 0) begin
                p = seg[s + OS * (db + 1)];
                x ^= p;
                f.pe = (cfg_par[i] == 1) ? !x : x;
                if (p) allzero = 1'b0;
            end
            for (int k = 0; k < sb; k++) begin
                if (!seg[s + OS * (db + np + 1 + k)]) f.fe = 1'b1;
                else allzero = 1'b0;
            end
            f.bk = allzero;
            push_exp(i, f);
            j = last + 1;
        end
    endtask

    // One os_tick period of four clocks; the level settles through both synchroniser depths before the tick edge.
    task automatic do_tick(input bit level);
        uart_rx = level;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 os_tick = 1'b1;
        @(posedge clk);
        #1 os_tick = 1'b0;
    endtask

    task automatic drive_seg();
        for (int k = 0; k < seg.size(); k++) do_tick(seg[k]);
        seg.delete();
    endtask

    task automatic run_segment(input int tail_bits);
        add_bits(1'b1, tail_bits);
        for (int i = 0; i < 3; i++) model(i);
        drive_seg();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic drain_checks(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_u%0d_pending", tag, i), exp_size(i), 0);
            check($sformatf("%s_u%0d_busy", tag, i), busy[i], 1'b0);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int data;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid, 3'b000);
        check("rst_busy", busy, 3'b000);
        check("rst_flags", {pe, fe, bk, ovr}, 12'h000);
        check("rst_data", {d0, d1, d2}, 23'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 0xA5, 8N1
        add_bits(1'b1, 1);
        add_frame(0, 8'hA5, 1'b0, 2'b00, 1);
        run_segment(14);
        drain_checks("a5");

        // Even parity: wrong parity bit, then correct
        add_bits(1'b1, 1);
        add_frame(1, 8'h3C, 1'b1, 2'b00, 2);
        add_frame(1, 8'h3C, 1'b0, 2'b00, 2);
        run_segment(14);
        drain_checks("par");

        // Stop bit low
        add_bits(1'b1, 1);
        add_frame(0, 8'h55, 1'b0, 2'b01, 2);
        run_segment(14);
        drain_checks("stop_low");

        // Break: line low for 12 bit periods
        add_bits(1'b1, 1);
        add_bits(1'b0, 12);
        run_segment(14);
        drain_checks("break");

        // Overrun on u0: 0x11 is held, 0x22 is dropped
        rdy[0] = 1'b0;
        add_bits(1'b1, 1);
        add_frame(0, 8'h11, 1'b0, 2'b00, 1);
        add_frame(0, 8'h22, 1'b0, 2'b00, 1);
        add_bits(1'b1, 14);
        for (int i = 0; i < 3; i++) model(i);
        if (exp0.size() > 1) exp0.delete(1);
        exp_ovr[0] = exp_ovr[0] + 1;
        drive_seg();
        repeat (4) @(posedge clk);
        #1;
        check("ovr_pulses", ovr_cnt[0], exp_ovr[0]);
        check("ovr_held_valid", valid[0], 1'b1);
        check("ovr_held_data", d0, 8'h11);
        rdy[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("ovr_valid_drop", valid[0], 1'b0);
        drain_checks("ovr");

        // Three-tick low glitch is rejected
        add_ticks(1'b1, 5);
        add_ticks(1'b0, 3);
        add_bits(1'b1, 3);
        run_segment(2);
        drain_checks("glitch");
        check("glitch_valid", valid, 3'b000);

        // Reset in the middle of DATA
        add_bits(1'b1, 1);
        add_bits(1'b0, 1);
        add_bits(1'b1, 1);
        add_bits(1'b0, 3);
        drive_seg();
        check("mid_busy", busy, 3'b111);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 3'b000);
        check("mid_rst_valid", valid, 3'b000);
        check("mid_rst_flags", {pe, fe, bk, ovr}, 12'h000);
        check("mid_rst_data", {d0, d1, d2}, 23'h0);
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        add_bits(1'b1, 1);
        add_frame(0, 8'h81, 1'b0, 2'b00, 1);
        run_segment(14);
        drain_checks("after_rst");

        // 7N2 back to back, no idle gap
        add_bits(1'b1, 1);
        add_frame(2, 7'h7F, 1'b0, 2'b00, 0);
        add_frame(2, 7'h00, 1'b0, 2'b00, 0);
        run_segment(14);
        drain_checks("b2b");

        // Randomised frames across all three layouts
        for (int sgi = 0; sgi < 6; sgi++) begin
            add_bits(1'b1, 1);
            for (int f = 0; f < 3; f++) begin
                int c;
                c = $urandom_range(0, 2);
                data = int'($urandom_range(0, 511));
                add_frame(c, data, ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                          $urandom_range(0, 2));
            end
            run_segment(14);
            drain_checks($sformatf("rnd%0d", sgi));
        end

        for (int i = 0; i < 3; i++) check($sformatf("u%0d_overrun_total", i), ovr_cnt[i], exp_ovr[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Next-generation UART receiver running on the system clock, qualified by an oversampling tick from the baud generator.
- Detects the start bit and samples each bit at mid-period.
- Supports a configurable frame: data width, parity mode and stop-bit count.
- Delivers each byte through a single-entry valid/ready holding register, with per-frame error flags and overrun detection; sits between the UART pin and the command/FIFO layer.

Parameters:
- DATA_BITS, 8, data bits per frame, legal range 5..9, sent LSB first.
- OS_RATE, 16, os_tick pulses per bit period; even, >= 4.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits checked, 1 or 2.
- SYNC_STAGES, 2, flip-flops in the uart_rx synchroniser, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset: asynchronous, active-low.
- os_tick  input  1  one-clk pulse, OS_RATE pulses per bit period.
- uart_rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  DATA_BITS  received data, valid while rx_valid = 1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- parity_err  output  1  parity mismatch for the frame in rx_data; 0 when PARITY = 0.
- frame_err  output  1  at least one stop bit sampled low for the frame in rx_data.
- break_det  output  1  all data, parity and stop samples low for the frame in rx_data.
- overrun_err  output  1  one-clk pulse when a completed frame is dropped.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset values: rx_data = 0; rx_valid, parity_err, frame_err, break_det, overrun_err, busy = 0. FSM = IDLE, counters = 0, synchroniser preset to 1.
- rst_n low mid-frame aborts the frame; nothing is delivered.
- uart_rx passes through SYNC_STAGES flops; "rx_s" below is the synchronised value. The FSM advances only on clk edges where os_tick = 1.
- IDLE: on a tick with rx_s = 0, go to START and clear the tick counter.
- START: on tick count OS_RATE/2-1 (mid-bit), sample rx_s.
  - 1: false start, return to IDLE, no flags.
  - 0: go to DATA, clear the tick and bit counters.
- DATA: sample every OS_RATE ticks into bit[bit_cnt], LSB first. After DATA_BITS samples go to PARITY if PARITY != 0, else STOP.
- PARITY: sample after OS_RATE ticks.
  - Odd mode: error if XOR(data, p) = 0.
  - Even mode: error if XOR(data, p) = 1.
- STOP: sample after OS_RATE ticks, repeated STOP_BITS times. Any low sample sets the frame's frame_err.
- The frame completes at the tick of the last stop sample; the FSM returns to IDLE on that same edge, so a start bit immediately following the mid-stop point is detected.
- Delivery, on the completing edge:
  - Holding register empty, or being emptied in the same cycle (rx_valid && rx_ready): load rx_data and all three error flags; rx_valid = 1 from the next cycle.
  - Otherwise: the frame is dropped, overrun_err pulses 1 clk, and the held data and flags are unchanged.
- break_det = 1 iff every sampled data bit, the parity bit (if any) and every stop bit are 0. frame_err is also 1 in that case.
- rx_valid clears on the cycle after rx_valid && rx_ready unless a new frame loads in the same cycle. Flags are meaningful only while rx_valid = 1.
- Latency: rx_valid rises 1 clk after the completing tick edge. Line-to-sample delay is SYNC_STAGES clk plus tick quantisation.
- Glitch rejection: a low pulse shorter than OS_RATE/2 ticks is rejected by the START re-check.

Test Plan:
- Default params, send 0xA5 with 1 stop bit, rx_ready = 1 → rx_valid one cycle with rx_data = 0xA5, all error flags 0.
- PARITY = 2, send 0x3C with parity bit 1 → parity_err = 1. Resend with parity bit 0 → parity_err = 0, rx_data = 0x3C.
- Stop bit driven low for 0x55 → frame_err = 1, break_det = 0. Line held low for 12 bit periods → break_det = 1, frame_err = 1, rx_data = 0x00, then IDLE once the line goes high.
- rx_ready = 0, send 0x11 then 0x22 → rx_data stays 0x11 and overrun_err pulses exactly once at 0x22 completion. Raise rx_ready → rx_valid drops, busy = 0.
- Low glitch of 3 ticks (OS_RATE = 16) → no state beyond START, rx_valid stays 0. Assert rst_n = 0 mid-DATA → all outputs 0 and the next 0x81 frame is received correctly.
- DATA_BITS = 7, STOP_BITS = 2, back-to-back frames 0x7F, 0x00 with no idle gap → both delivered in order, no errors.
